// File: rtl/ltop_multi.sv
// Multi-channel level debouncer with edge pulses: synchroniser, per-channel debounce counter,
// registered stable level and edge pulse. Optional auto-repeat is compiled in with LTOP_REPEAT_EN.
module ltop_multi #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 4,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] L,
  output logic [N-1:0] P,
  output logic [N-1:0] LS
);

  // Out-of-range edge modes fall back to rising-edge pulses.
  localparam int EM = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  ls_q, ls_d;
  logic [N-1:0]  p_q, p_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

`ifdef LTOP_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_SAT    = '1;

  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];
  logic [N-1:0]  rep_q, rep_d;   // set once the first repeat has fired
`endif

  // Debounce and edge detection; a change is accepted on the DB_CYCLES-th
  // consecutive cycle the synced level differs from the stable level.
  always_comb begin
    ls_d = ls_q;
    p_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == ls_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        ls_d[i]  = s2_q[i];
        case (EM)
          0:       p_d[i] = s2_q[i];
          1:       p_d[i] = ~s2_q[i];
          default: p_d[i] = 1'b1;
        endcase
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

`ifdef LTOP_REPEAT_EN
    rep_d = '0;
    for (int i = 0; i < N; i++) begin
      hold_d[i] = '0;
      if (EM == 0 && ls_q[i] && ls_d[i]) begin
        // Level stays high: count towards the next repeat, saturating.
        rep_d[i]  = rep_q[i];
        hold_d[i] = hold_q[i];
        if (hold_q[i] == (rep_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          p_d[i]    = 1'b1;
          hold_d[i] = '0;
          rep_d[i]  = 1'b1;
        end else if (hold_q[i] != HOLD_SAT) begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      ls_q <= '0;
      p_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= L;
      s2_q <= s1_q;
      ls_q <= ls_d;
      p_q  <= p_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef LTOP_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
      for (int i = 0; i < N; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < N; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
`endif

  assign P  = p_q;
  assign LS = ls_q;

endmodule

// File: doc/ltop_multi.md
LTOP_MULTI -- requirements
Module: ltop_multi

Interface
REQ-001 SHALL have parameter N, 4, number of independent channels (1..32).
REQ-002 SHALL have parameter DB_CYCLES, 4, consecutive cycles a synced level must differ from the stable level before it is accepted (1..65535).
REQ-003 SHALL have parameter EDGE_MODE, 0, pulse source: 0 rising, 1 falling, 2 both edges of the stable level.
REQ-004 SHALL have parameter REPEAT_DELAY, 500, hold cycles from rising-edge pulse to first repeat pulse (used only with LTOP_REPEAT_EN).
REQ-005 SHALL have parameter REPEAT_PERIOD, 100, cycles between subsequent repeat pulses (used only with LTOP_REPEAT_EN).
REQ-006 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst input 1: synchronous, active-high reset.
REQ-008 SHALL have port L input N: asynchronous raw levels, one bit per channel.
REQ-009 SHALL have port P output N: registered one-cycle pulses, one bit per channel.
REQ-010 SHALL have port LS output N: registered debounced stable level per channel.

Function
REQ-011 SHALL pass each L[i] through a two-flop synchroniser (s1, s2) before any other logic.
REQ-012 SHALL keep a per-channel debounce counter: cleared whenever s2[i]==LS[i]; incremented while s2[i]!=LS[i].
REQ-013 SHALL load LS[i] with s2[i] on the edge where s2[i]!=LS[i] and the counter equals DB_CYCLES-1, clearing the counter on the same edge.
REQ-014 SHALL make a clean L[i] transition visible on LS[i] exactly DB_CYCLES+2 rising edges after it is first sampled.
REQ-015 SHALL suppress any synced excursion shorter than DB_CYCLES cycles: no LS change, no pulse, counter restarts from 0.
REQ-016 SHALL assert P[i] for exactly one cycle, coincident with the first cycle LS[i] shows the new value, when that change matches EDGE_MODE.
REQ-017 SHALL never assert P[i] on two consecutive cycles; minimum spacing between edge pulses is DB_CYCLES cycles.
REQ-018 SHALL process all channels independently; simultaneous edges on several channels yield simultaneous pulses.
REQ-019 SHALL treat EDGE_MODE values other than 0, 1, 2 as 0.

Reset
REQ-020 SHALL clear s1, s2, LS, P, debounce and repeat counters to 0 on any clk edge with rst=1, including mid-debounce and mid-repeat.
REQ-021 SHALL give rst priority over all other updates; P SHALL be 0 during and on the first cycle after reset.
REQ-022 SHALL, for an L[i] held high through reset release, raise LS[i] DB_CYCLES+2 edges after the first edge with rst=0, with a rising pulse if EDGE_MODE is 0 or 2.

Configuration
REQ-023 SHALL use macro LTOP_REPEAT_EN to compile auto-repeat in or out.
REQ-024 With LTOP_REPEAT_EN and EDGE_MODE==0: while LS[i]==1, a per-channel hold counter runs from the rising-edge pulse; P[i] pulses again REPEAT_DELAY cycles after that pulse, then every REPEAT_PERIOD cycles.
REQ-025 With LTOP_REPEAT_EN: LS[i] falling SHALL clear the hold counter on that edge and emit no further repeat pulse; the counter SHALL saturate, never wrap, between pulses.
REQ-026 Without LTOP_REPEAT_EN: no hold counters SHALL exist, REPEAT_* SHALL be ignored, and P SHALL carry edge pulses only.

Verification
REQ-027 N=4, DB_CYCLES=4, EDGE_MODE=0: L[0] 0->1 held -> LS[0]=1 and P[0]=1 for one cycle, 6 edges after L change; P[3:1]=0.
REQ-028 Same config: L[1] high for 3 cycles then low -> LS[1] and P[1] stay 0 throughout.
REQ-029 EDGE_MODE=2: L[2] 0->1, hold 20 cycles, 1->0 -> two single-cycle P[2] pulses 20 cycles apart.
REQ-030 L=4'b1111 asserted together -> P=4'b1111 for exactly one cycle; rst=1 asserted 2 cycles into debounce of a new change -> LS=0, P=0, no pulse from the aborted change.
REQ-031 LTOP_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3: L[0] held 20 cycles after LS rise -> P[0] at t, t+10, t+13, t+16, t+19; release -> no further pulses.
REQ-032 LTOP_REPEAT_EN undefined, same stimulus -> single P[0] pulse at t only.
